// File: rtl/dense_layer_seq.sv
// dense_layer_seq: sequential fully-connected layer with one MAC per row and one column per cycle.
// It has local weight/bias storage, ready/valid handshakes and a selectable activation.
module dense_layer_seq #(
   parameter int ROWS       = 30,
   parameter int COLUMNS    = 64,
   parameter int DATAWIDTH  = 11,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                              clk,
   input  logic                              rst_overall,
   input  logic [COLUMNS*DATAWIDTH-1:0]      values,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [1:0]                        act_mode,
   input  logic                              w_wr_en,
   input  logic [$clog2(ROWS)-1:0]           w_row,
   input  logic [COLUMNS*DATAWIDTH-1:0]      w_data,
   input  logic                              b_wr_en,
   input  logic                              b_mode,
   input  logic [ROWS*2*DATAWIDTH-1:0]       b_data,
   output logic                              wr_err,
   output logic [ROWS*2*DATAWIDTH-1:0]       out,
   output logic                              out_valid,
   input  logic                              out_ready
);
   localparam int DW = DATAWIDTH;
   localparam int OW = 2*DW;
   localparam int AW = OW + $clog2(COLUMNS) + 1;
   localparam int CW = COLUMNS > 1 ? $clog2(COLUMNS) : 1;
   localparam logic signed [AW-1:0] MAX_V = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] MIN_V = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, FINISH, HOLD} state_t;
   state_t state_q, state_d;

   logic signed [DW-1:0] w_q   [ROWS][COLUMNS];
   logic signed [DW-1:0] x_q   [COLUMNS];
   logic signed [OW-1:0] b_q   [ROWS];
   logic signed [AW-1:0] acc_q [ROWS];
   logic [CW-1:0]        col_q;
   logic [1:0]           mode_q;
   logic                 wr_err_q;
   logic [ROWS*OW-1:0]   out_q, out_d;
   logic                 idle, accept, w_ok, drop;

   function automatic logic signed [OW-1:0] sat(input logic signed [AW-1:0] v);
      return v > MAX_V ? MAX_V[OW-1:0] : v < MIN_V ? MIN_V[OW-1:0] : v[OW-1:0];
   endfunction

   // The shift is kept in its own signed variable so it stays arithmetic.
   function automatic logic signed [OW-1:0] act(input logic [1:0] m, input logic signed [OW-1:0] v);
      logic signed [OW-1:0] lk;
      lk = v >>> LEAK_SHIFT;
      return (v[OW-1] && m == 2'd1) ? '0 : (v[OW-1] && m == 2'd2) ? lk : v;
   endfunction

   function automatic logic signed [OW-1:0] mul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
      return OW'(a) * OW'(b);
   endfunction

   assign idle      = state_q == IDLE;
   assign in_ready  = idle && !rst_overall;
   assign accept    = in_valid && in_ready;
   assign w_ok      = int'(w_row) < ROWS;
   assign drop      = (w_wr_en && !(idle && w_ok)) || (b_wr_en && !idle);
   assign wr_err    = wr_err_q;
   assign out       = out_q;
   assign out_valid = state_q == HOLD;

   always_comb begin
      state_d = idle ? (in_valid ? MAC : IDLE) :
                state_q == MAC ? (col_q == CW'(COLUMNS-1) ? FINISH : MAC) :
                state_q == FINISH ? HOLD : (out_ready ? IDLE : HOLD);
   end

   always_comb begin
      out_d = '0;
      for (int i = 0; i < ROWS; i++)
         out_d[(ROWS-1-i)*OW +: OW] = act(mode_q, sat(acc_q[i] + AW'(b_q[i])));
   end

   always_ff @(posedge clk)
      state_q <= rst_overall ? IDLE : state_d;

   always_ff @(posedge clk) begin
      if (rst_overall) begin
         col_q    <= '0;
         mode_q   <= '0;
         wr_err_q <= 1'b0;
         out_q    <= '0;
         for (int i = 0; i < ROWS; i++) begin
            acc_q[i] <= '0;
            b_q[i]   <= '0;
            for (int j = 0; j < COLUMNS; j++) w_q[i][j] <= '0;
         end
         for (int j = 0; j < COLUMNS; j++) x_q[j] <= '0;
      end else begin
         wr_err_q <= drop;
         if (idle && w_wr_en && w_ok)
            for (int j = 0; j < COLUMNS; j++)
               w_q[w_row][j] <= $signed(w_data[(COLUMNS-1-j)*DW +: DW]);
         if (idle && b_wr_en)
            for (int i = 0; i < ROWS; i++)
               b_q[i] <= b_mode ? sat(AW'(b_q[i]) + AW'($signed(b_data[(ROWS-1-i)*OW +: OW])))
                                : $signed(b_data[(ROWS-1-i)*OW +: OW]);
         if (accept) begin
            mode_q <= act_mode;
            col_q  <= '0;
            for (int j = 0; j < COLUMNS; j++) x_q[j] <= $signed(values[(COLUMNS-1-j)*DW +: DW]);
            for (int i = 0; i < ROWS; i++) acc_q[i] <= '0;
         end
         if (state_q == MAC) begin
            col_q <= col_q + 1'b1;
            for (int i = 0; i < ROWS; i++) acc_q[i] <= acc_q[i] + AW'(mul(w_q[i][col_q], x_q[col_q]));
         end
         if (state_q == FINISH) out_q <= out_d;
      end
   end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed and randomized checks of dense_layer_seq against an arithmetic model.
module tb_dense_layer_seq;
   localparam int R = 3, C = 4, DW = 8, OW = 16, LS = 2;

   logic clk = 1'b0;
   logic rst_overall = 1'b0, in_valid = 1'b0, w_wr_en = 1'b0, b_wr_en = 1'b0, b_mode = 1'b0, out_ready = 1'b0;
   logic in_ready, wr_err, out_valid;
   logic [C*DW-1:0] values = '0, w_data = '0;
   logic [1:0] act_mode = '0, w_row = '0;
   logic [R*OW-1:0] b_data = '0, out;

   int n_cmp = 0, n_bad = 0;
   int W[R][C], B[R], xv[C], wv[C], bv[R];

   always #5 clk = ~clk;

   dense_layer_seq #(.ROWS(R), .COLUMNS(C), .DATAWIDTH(DW), .LEAK_SHIFT(LS)) dut (
      .clk(clk), .rst_overall(rst_overall), .values(values), .in_valid(in_valid), .in_ready(in_ready),
      .act_mode(act_mode), .w_wr_en(w_wr_en), .w_row(w_row), .w_data(w_data), .b_wr_en(b_wr_en),
      .b_mode(b_mode), .b_data(b_data), .wr_err(wr_err), .out(out), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int sat16(longint v);
      return v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
   endfunction

   function automatic int model_row(int i, int m);
      longint s = B[i];
      int v;
      for (int j = 0; j < C; j++) s += longint'(W[i][j]) * xv[j];
      v = sat16(s);
      return (v < 0 && m == 1) ? 0 : (v < 0 && m == 2) ? (v >>> LS) : v;
   endfunction

   task automatic clear_model;
      for (int i = 0; i < R; i++) begin
         B[i] = 0;
         for (int j = 0; j < C; j++) W[i][j] = 0;
      end
   endtask

   task automatic check_out(input string tag, input int m);
      for (int i = 0; i < R; i++)
         check($sformatf("%s_row%0d", tag, i), $signed(out[(R-1-i)*OW +: OW]), model_row(i, m));
   endtask

   task automatic do_reset;
      rst_overall = 1'b1; in_valid = 1'b1; w_wr_en = 1'b1; w_row = '0; w_data = '1; b_wr_en = 1'b1; b_data = '1;
      #1;
      check("in_ready_in_reset", in_ready, 0);
      tick;
      tick;
      rst_overall = 1'b0; in_valid = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
      clear_model();
      #1;
      check("in_ready_after_reset", in_ready, 1);
      check("out_valid_after_reset", out_valid, 0);
      check("wr_err_after_reset", wr_err, 0);
      check("out_after_reset", out, 0);
   endtask

   task automatic wr_w(input int row);
      w_wr_en = 1'b1;
      w_row = 2'(row);
      for (int j = 0; j < C; j++) w_data[(C-1-j)*DW +: DW] = 8'(wv[j]);
      tick;
      w_wr_en = 1'b0;
      check("wr_err_wrow", wr_err, row >= R);
      if (row < R) for (int j = 0; j < C; j++) W[row][j] = wv[j];
   endtask

   task automatic wr_b(input int m);
      b_wr_en = 1'b1;
      b_mode = m[0];
      for (int i = 0; i < R; i++) b_data[(R-1-i)*OW +: OW] = 16'(bv[i]);
      tick;
      b_wr_en = 1'b0;
      check("wr_err_bias", wr_err, 0);
      for (int i = 0; i < R; i++) B[i] = m != 0 ? sat16(longint'(B[i]) + bv[i]) : bv[i];
   endtask

   task automatic run(input int m, input int hold);
      int n = 0;
      for (int j = 0; j < C; j++) values[(C-1-j)*DW +: DW] = 8'(xv[j]);
      act_mode = 2'(m);
      in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1);
      tick;
      in_valid = 1'b0;
      values = $urandom;
      act_mode = 2'($urandom);
      check("in_ready_busy", in_ready, 0);
      while (!out_valid && n < 20) begin
         tick;
         n++;
      end
      check("latency", n, C + 1);
      check_out("result", m);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         if (k == 3) begin
            w_wr_en = 1'b1; b_wr_en = 1'b1; b_mode = 1'b0; w_row = '0; w_data = $urandom; b_data = '1;
         end
         tick;
         in_valid = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         if (k == 3) check("busy_wr_err", wr_err, 1);
         if (k == 4) check("busy_wr_err_pulse", wr_err, 0);
         check_out("hold", m);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check("valid_after_handshake", out_valid, 0);
      check("ready_after_handshake", in_ready, 1);
      check_out("kept", m);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      xv = '{5, 6, 7, 8};
      run(0, 0);

      wv = '{1, 2, 3, 4};     wr_w(0);
      wv = '{-1, -1, -1, -1}; wr_w(1);
      wv = '{0, 0, 0, 0};     wr_w(2);
      bv = '{10, 0, -5};      wr_b(0);
      xv = '{1, 1, 1, 1};
      run(0, 0);
      check("plan_mode0", $signed(out[(R-1)*OW +: OW]), 20);
      run(1, 0);
      run(2, 0);
      check("plan_leaky_row2", $signed(out[0 +: OW]), -2);

      wv = '{127, 127, 127, 127}; wr_w(0);
      bv = '{0, 0, 0};            wr_b(0);
      xv = '{127, 127, 127, 127};
      run(0, 0);
      wv = '{-128, -128, -128, -128}; wr_w(0);
      run(3, 0);
      wv = '{0, 0, 0, 0}; wr_w(0);
      bv = '{32767, -32768, 5}; wr_b(0);
      bv = '{1, -1, 2};         wr_b(1);
      wv = '{9, 9, 9, 9};       wr_w(3);
      xv = '{3, -2, 1, 0};
      run(0, 0);

      run(2, 10);
      run(2, 0);

      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(1) == 1) begin
            for (int j = 0; j < C; j++) wv[j] = int'($urandom_range(255)) - 128;
            wr_w(int'($urandom_range(3)));
         end
         if ($urandom_range(2) == 0) begin
            for (int i = 0; i < R; i++) bv[i] = int'($urandom_range(65535)) - 32768;
            wr_b(int'($urandom_range(1)));
         end
         for (int j = 0; j < C; j++) xv[j] = int'($urandom_range(255)) - 128;
         run(int'($urandom_range(3)), int'($urandom_range(2)));
      end

      for (int j = 0; j < C; j++) values[(C-1-j)*DW +: DW] = 8'($urandom);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      do_reset();
      begin
         int seen = 0;
         for (int k = 0; k < 10; k++) begin
            tick;
            if (out_valid) seen++;
         end
         check("no_valid_after_abort", seen, 0);
      end
      for (int j = 0; j < C; j++) xv[j] = int'($urandom_range(255)) - 128;
      run(int'($urandom_range(3)), 0);
      check("abort_row0_zero", $signed(out[(R-1)*OW +: OW]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
